// File: rtl/ip_amba_apb_master.sv
// ---------------------------------------------------------------------------
// ip_amba_apb_master
//
// Single-outstanding APB master. A command taken on the cmd_* port becomes
// one APB transfer (SETUP then ACCESS), and its result is returned on rsp_*.
// An ACCESS phase that waits too long on PREADY is aborted with a timeout.
//
// Ports
//   PCLK, PRESET         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake; cmd_addr, cmd_write, cmd_wdata,
//                          cmd_strb, cmd_prot, cmd_sel carry the command
//   rsp_valid/rsp_ready  : response handshake; rsp_rdata, rsp_err,
//                          rsp_timeout carry the result
//   PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB : APB request
//   PREADY, PRDATA, PSLVERR                            : APB completion
//
// Handshake rule (both cmd and rsp): a transfer happens on a PCLK edge where
// valid and ready are both 1. The producer holds valid and its payload stable
// until that edge; ready may be asserted independently of valid.
//
// cmd_sel is one bit wider than a plain index so that out-of-range slave
// numbers can be expressed; they complete immediately with an error.
// All outputs are flops.
// ---------------------------------------------------------------------------
module ip_amba_apb_master #(
  parameter int PADDR_width    = 32,
  parameter int PWDATA_width   = 32,
  parameter int PRDATA_width   = 32,
  parameter int PSTRB_width    = 4,
  parameter int PSELx_width    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                  PCLK,
  input  logic                                  PRESET,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [PADDR_width-1:0]                cmd_addr,
  input  logic                                  cmd_write,
  input  logic [PWDATA_width-1:0]               cmd_wdata,
  input  logic [PSTRB_width-1:0]                cmd_strb,
  input  logic [2:0]                            cmd_prot,
  input  logic [$clog2(PSELx_width+1)-1:0]      cmd_sel,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [PRDATA_width-1:0]               rsp_rdata,
  output logic                                  rsp_err,
  output logic                                  rsp_timeout,
  output logic [PADDR_width-1:0]                PADDR,
  output logic [2:0]                            PPROT,
  output logic [PSELx_width-1:0]                PSELx,
  output logic                                  PENABLE,
  output logic                                  PWRITE,
  output logic [PWDATA_width-1:0]               PWDATA,
  output logic [PSTRB_width-1:0]                PSTRB,
  input  logic                                  PREADY,
  input  logic [PRDATA_width-1:0]               PRDATA,
  input  logic                                  PSLVERR
);

  localparam int SEL_W = $clog2(PSELx_width + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(PSELx_width);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PSELx_width-1:0] SEL_ONE = {{(PSELx_width-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]          wait_inc;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [PRDATA_width-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [PADDR_width-1:0]    paddr_q, paddr_d;
  logic [2:0]                pprot_q, pprot_d;
  logic [PSELx_width-1:0]    psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [PWDATA_width-1:0]   pwdata_q, pwdata_d;
  logic [PSTRB_width-1:0]    pstrb_q, pstrb_d;

  assign wait_inc = wait_cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready rises one cycle after reset release or after a response
        // is consumed, so no command is ever taken on those edges.
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          paddr_d     = cmd_addr;
          pprot_d     = cmd_prot;
          pwrite_d    = cmd_write;
          // Reads put nothing on the write-data lanes.
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb  : '0;
          if (cmd_sel < SEL_LIMIT) begin
            state_d    = SETUP;
            psel_d     = SEL_ONE << cmd_sel;
            penable_d  = 1'b0;
            wait_cnt_d = '0;
          end else begin
            // No such slave: answer straight away without touching the bus.
            state_d       = RESP;
            psel_d        = '0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        // PREADY wins over the timeout when both land on the same cycle.
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == CNT_LIMIT) begin
            state_d       = RESP;
            psel_d        = '0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PPROT       = pprot_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_ip_amba_apb_master.sv
// ---------------------------------------------------------------------------
// tb_ip_amba_apb_master
//
// Directed bench for ip_amba_apb_master with default parameters. A table of
// per-cycle records (inputs plus expected registered outputs after the edge)
// covers ordinary writes/reads, wait states and bad slave indices; short
// hand-written sequences cover timeout, PREADY-at-limit, response stall and
// reset in the middle of a transfer. Inputs change #1 after a rising edge;
// outputs are read #1 after the following rising edge.
// ---------------------------------------------------------------------------
module tb_ip_amba_apb_master;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic [2:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic [3:0]  PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  ip_amba_apb_master dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PPROT       (PPROT),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR)
  );

  // ---------------- clock ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector record ----------------
  typedef struct {
    string       nm;
    logic        cv;
    logic        cw;
    logic [2:0]  cs;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [3:0]  cst;
    logic        pr;
    logic [31:0] prd;
    logic        perr;
    logic        rr;
    logic        e_cr;
    logic [3:0]  e_sel;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [31:0] e_wd;
    logic [3:0]  e_st;
    logic        e_rv;
    logic        e_err;
    logic        e_to;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    string nm, logic cv, logic cw, logic [2:0] cs, logic [31:0] ca, logic [31:0] cd,
    logic [3:0] cst, logic pr, logic [31:0] prd, logic perr, logic rr,
    logic e_cr, logic [3:0] e_sel, logic e_en, logic [31:0] e_addr, logic e_wr,
    logic [31:0] e_wd, logic [3:0] e_st, logic e_rv, logic e_err, logic e_to, logic [31:0] e_rd);
    vec_t v;
    v.nm = nm; v.cv = cv; v.cw = cw; v.cs = cs; v.ca = ca; v.cd = cd; v.cst = cst;
    v.pr = pr; v.prd = prd; v.perr = perr; v.rr = rr;
    v.e_cr = e_cr; v.e_sel = e_sel; v.e_en = e_en; v.e_addr = e_addr; v.e_wr = e_wr;
    v.e_wd = e_wd; v.e_st = e_st; v.e_rv = e_rv; v.e_err = e_err; v.e_to = e_to; v.e_rd = e_rd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; cmd_sel = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
  endtask

  // Present a command for one edge; the caller knows cmd_ready is 1.
  task automatic issue(input logic wr, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel; cmd_addr = addr;
    cmd_wdata = wd; cmd_strb = st; cmd_prot = prot;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_rsp(input string nm);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, ".rsp_valid_after_pop"}, 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".cmd_ready"},   32'(cmd_ready),   32'd0);
    chk({nm, ".rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({nm, ".rsp_rdata"},   rsp_rdata,        32'd0);
    chk({nm, ".rsp_err"},     32'(rsp_err),     32'd0);
    chk({nm, ".rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({nm, ".PADDR"},       PADDR,            32'd0);
    chk({nm, ".PPROT"},       32'(PPROT),       32'd0);
    chk({nm, ".PSELx"},       32'(PSELx),       32'd0);
    chk({nm, ".PENABLE"},     32'(PENABLE),     32'd0);
    chk({nm, ".PWRITE"},      32'(PWRITE),      32'd0);
    chk({nm, ".PWDATA"},      PWDATA,           32'd0);
    chk({nm, ".PSTRB"},       32'(PSTRB),       32'd0);
  endtask

  // ---------------- test ----------------
  initial begin : main
    int en_cycles;
    int guard;

    // cv cw sel addr wdata strb | PREADY PRDATA PSLVERR rsp_ready ||
    // cmd_ready PSELx PENABLE PADDR PWRITE PWDATA PSTRB rsp_valid err timeout rdata
    tbl.push_back(mk("wr_accept",  1'b1, 1'b1, 3'd1, 32'h10, 32'hA5A5_0F0F, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b0010, 1'b0, 32'h10, 1'b1, 32'hA5A5_0F0F, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr_setup",   1'b0, 1'b0, 3'd3, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b0010, 1'b1, 32'h10, 1'b1, 32'hA5A5_0F0F, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr_access",  1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b0,
                     1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr_pop_nocmd", 1'b1, 1'b0, 3'd2, 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("rd_accept",  1'b1, 1'b0, 3'd2, 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b0100, 1'b0, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("rd_setup_ign", 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0,
                     1'b0, 4'b0100, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    for (int w = 1; w <= 3; w++)
      tbl.push_back(mk($sformatf("rd_wait%0d", w), 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                       1'b0, 4'b0100, 1'b1, 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("rd_ready",   1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0,
                     1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_5678));
    tbl.push_back(mk("rd_pop",     1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("bad_sel5",   1'b1, 1'b1, 3'd5, 32'h30, 32'h0BAD_F00D, 4'h3, 1'b1, 32'h9999_9999, 1'b0, 1'b0,
                     1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk("bad5_pop",   1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("bad_sel4",   1'b1, 1'b0, 3'd4, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk("bad4_pop",   1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr3_accept", 1'b1, 1'b1, 3'd3, 32'hFFFF_FFF0, 32'h0102_0304, 4'h5, 1'b0, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b1000, 1'b0, 32'hFFFF_FFF0, 1'b1, 32'h0102_0304, 4'h5, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr3_setup",  1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                     1'b0, 4'b1000, 1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0102_0304, 4'h5, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("wr3_slverr", 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h7777_7777, 1'b1, 1'b0,
                     1'b0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk("wr3_pop",    1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1,
                     1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0));

    // ---- reset ----
    idle_inputs();
    PRESET = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    PRESET = 1'b0;
    step();
    chk("reset_release.cmd_ready", 32'(cmd_ready), 32'd1);

    // ---- table-driven vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].cv; cmd_write = tbl[i].cw; cmd_sel = tbl[i].cs;
      cmd_addr = tbl[i].ca; cmd_wdata = tbl[i].cd; cmd_strb = tbl[i].cst; cmd_prot = 3'd0;
      PREADY = tbl[i].pr; PRDATA = tbl[i].prd; PSLVERR = tbl[i].perr; rsp_ready = tbl[i].rr;
      step();
      chk({tbl[i].nm, ".cmd_ready"}, 32'(cmd_ready), 32'(tbl[i].e_cr));
      chk({tbl[i].nm, ".PSELx"},     32'(PSELx),     32'(tbl[i].e_sel));
      chk({tbl[i].nm, ".PENABLE"},   32'(PENABLE),   32'(tbl[i].e_en));
      chk({tbl[i].nm, ".rsp_valid"}, 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_sel != 4'd0) begin
        chk({tbl[i].nm, ".PADDR"},  PADDR,          tbl[i].e_addr);
        chk({tbl[i].nm, ".PWRITE"}, 32'(PWRITE),    32'(tbl[i].e_wr));
        chk({tbl[i].nm, ".PWDATA"}, PWDATA,         tbl[i].e_wd);
        chk({tbl[i].nm, ".PSTRB"},  32'(PSTRB),     32'(tbl[i].e_st));
      end
      if (tbl[i].e_rv) begin
        chk({tbl[i].nm, ".rsp_err"},     32'(rsp_err),     32'(tbl[i].e_err));
        chk({tbl[i].nm, ".rsp_timeout"}, 32'(rsp_timeout), 32'(tbl[i].e_to));
        chk({tbl[i].nm, ".rsp_rdata"},   rsp_rdata,        tbl[i].e_rd);
      end
    end
    idle_inputs();

    // ---- timeout: PREADY never rises ----
    issue(1'b0, 3'd0, 32'h8, 32'h0, 4'h0, 3'b101);
    chk("to.PPROT", 32'(PPROT), 32'd5);
    chk("to.PSELx_setup", 32'(PSELx), 32'b0001);
    step();
    en_cycles = 0;
    guard = 0;
    while (PENABLE && guard < 40) begin
      en_cycles++;
      guard++;
      step();
    end
    chk("to.access_cycles", 32'(en_cycles), 32'd16);
    chk("to.rsp_valid",   32'(rsp_valid),   32'd1);
    chk("to.rsp_err",     32'(rsp_err),     32'd1);
    chk("to.rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to.rsp_rdata",   rsp_rdata,        32'd0);
    chk("to.PSELx",       32'(PSELx),       32'd0);
    pop_rsp("to");

    // ---- PREADY on the 16th ACCESS cycle completes normally ----
    issue(1'b0, 3'd3, 32'hC, 32'h0, 4'h0, 3'b000);
    step();
    for (int k = 0; k < 15; k++) step();
    chk("edge.PENABLE_still", 32'(PENABLE), 32'd1);
    chk("edge.no_rsp_yet",    32'(rsp_valid), 32'd0);
    PREADY = 1'b1;
    PRDATA = 32'hCAFE_F00D;
    step();
    PREADY = 1'b0;
    chk("edge.rsp_valid",   32'(rsp_valid),   32'd1);
    chk("edge.rsp_err",     32'(rsp_err),     32'd0);
    chk("edge.rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("edge.rsp_rdata",   rsp_rdata,        32'hCAFE_F00D);
    pop_rsp("edge");

    // ---- PSLVERR on a read, response stalled for 5 cycles ----
    issue(1'b0, 3'd1, 32'h24, 32'h0, 4'h0, 3'b000);
    step();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h55AA_55AA;
    step();
    chk("slv.rsp_valid",   32'(rsp_valid),   32'd1);
    chk("slv.rsp_err",     32'(rsp_err),     32'd1);
    chk("slv.rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("slv.rsp_rdata",   rsp_rdata,        32'h55AA_55AA);
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_addr = 32'h100; cmd_write = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d.rsp_valid", k),   32'(rsp_valid),   32'd1);
      chk($sformatf("stall%0d.rsp_err", k),     32'(rsp_err),     32'd1);
      chk($sformatf("stall%0d.rsp_timeout", k), 32'(rsp_timeout), 32'd0);
      chk($sformatf("stall%0d.rsp_rdata", k),   rsp_rdata,        32'h55AA_55AA);
      chk($sformatf("stall%0d.cmd_ready", k),   32'(cmd_ready),   32'd0);
      chk($sformatf("stall%0d.PSELx", k),       32'(PSELx),       32'd0);
    end
    cmd_valid = 1'b0;
    pop_rsp("stall");
    chk("stall.cmd_ready_after", 32'(cmd_ready), 32'd1);
    PREADY = 1'b0;

    // ---- reset during ACCESS ----
    issue(1'b1, 3'd2, 32'h50, 32'h1357_2468, 4'hF, 3'b010);
    step();
    chk("rst.in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    step();
    chk_all_zero("rst_mid");
    PRESET = 1'b0;
    step();
    chk("rst_rel.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rel.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rel.PSELx",     32'(PSELx),     32'd0);
    PREADY = 1'b1; PSLVERR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_quiet%0d.rsp_valid", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("rst_quiet%0d.PSELx", k),     32'(PSELx),     32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
